// File: rtl/gray_sobel.sv
// ---- gray_sobel -------------------------------------------------------------
// 3x3 Sobel edge magnitude over a raster grayscale pixel stream.  rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module gray_sobel #(
  parameter int IMG_WIDTH = 640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Valid_in,
  input  logic [7:0] Gray_in,
  input  logic       Sof_in,
  output logic       Valid_out,
  output logic [7:0] Edge_out
);

  localparam int            CW         = $clog2(IMG_WIDTH);
  localparam int            RW         = 12;
  localparam logic [CW-1:0] C_LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] C_ROW_MAX  = '1;

  logic [CW-1:0] col_q, col_d, pos_col;
  logic [RW-1:0] row_q, row_d, pos_row;
  logic          v1_q, v1_d, v2_q, v2_d, valid_q, valid_d;
  logic [7:0]    edge_q, edge_d;
  logic [10:0]   ax_q, ax_d, ay_q, ay_d;
  logic [7:0]    tap0, tap1;
  logic [7:0]    lb0_q [IMG_WIDTH];
  logic [7:0]    lb1_q [IMG_WIDTH];
  logic [7:0]    win_q [3][3];
  logic [7:0]    win_d [3][3];
  logic [10:0]   gx_pos, gx_neg, gy_pos, gy_neg, gx, gy;
  logic [11:0]   sum;

  // A start-of-frame pixel is placed at (0,0) whatever the counters hold.
  always_comb begin
    pos_col = Sof_in ? '0 : col_q;
    pos_row = Sof_in ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (Valid_in) begin
      if (pos_col == C_LAST_COL) begin
        col_d = '0;
        row_d = (pos_row == C_ROW_MAX) ? pos_row : pos_row + RW'(1);
      end else begin
        col_d = pos_col + CW'(1);
        row_d = pos_row;
      end
    end
  end

  // lb1 holds the row above, lb0 the row two above; taps feed the window's new column.
  always_comb begin
    tap0  = lb0_q[pos_col];
    tap1  = lb1_q[pos_col];
    win_d = win_q;
    if (Valid_in) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 2; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      win_d[0][2] = tap0;
      win_d[1][2] = tap1;
      win_d[2][2] = Gray_in;
    end
    v1_d = Valid_in && (pos_row >= RW'(2)) && (pos_col >= CW'(2));
  end

  always_comb begin
    gx_pos = {3'b000, win_q[0][2]} + {2'b00, win_q[1][2], 1'b0} + {3'b000, win_q[2][2]};
    gx_neg = {3'b000, win_q[0][0]} + {2'b00, win_q[1][0], 1'b0} + {3'b000, win_q[2][0]};
    gy_pos = {3'b000, win_q[2][0]} + {2'b00, win_q[2][1], 1'b0} + {3'b000, win_q[2][2]};
    gy_neg = {3'b000, win_q[0][0]} + {2'b00, win_q[0][1], 1'b0} + {3'b000, win_q[0][2]};
    gx     = gx_pos - gx_neg;
    gy     = gy_pos - gy_neg;
    ax_d   = gx[10] ? (~gx + 11'd1) : gx;
    ay_d   = gy[10] ? (~gy + 11'd1) : gy;
    v2_d   = v1_q;
  end

  always_comb begin
    sum     = {1'b0, ax_q} + {1'b0, ay_q};
    valid_d = v2_q;
    edge_d  = edge_q;
    if (v2_q) begin
      edge_d = (sum > 12'd255) ? 8'hFF : sum[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      valid_q <= 1'b0;
      edge_q  <= 8'd0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      valid_q <= valid_d;
      edge_q  <= edge_d;
    end
  end

  // Pixel storage is left uncleared by reset; the row/col guard masks stale data.
  always_ff @(posedge clk) begin
    win_q <= win_d;
    ax_q  <= ax_d;
    ay_q  <= ay_d;
    if (Valid_in) begin
      lb0_q[pos_col] <= tap1;
      lb1_q[pos_col] <= Gray_in;
    end
  end

  assign Valid_out = valid_q;
  assign Edge_out  = edge_q;

endmodule

`default_nettype wire
